rv32i_core: RTL and testbench
=============================

// Module: rv32i_core
// PURPOSE
//  Single-cycle RV32I integer core: one instruction retires every clk rising edge.
//  Fetches from an instruction ROM by PC, accesses a data RAM by byte address.
//  Top of the didactic platform; ROM/RAM are external, wired at the system level.
// PARAMETERS
//  RESET_PC  32'h0000_0000  PC value loaded while reset_n is low
// PORTS
//  clk          in   1   single clock; all state updates on rising edge
//  reset_n      in   1   reset, asynchronous, active-low
//  instruction  in   32  instruction word at new_pc (ROM read is combinational)
//  mem_rd_data  in   32  word at {mem_addr[31:2],2'b00} (RAM read is combinational)
//  mem_wr_sig   out  1   RAM word write enable, sampled by RAM on rising clk
//  mem_wr_data  out  32  full word to write (already byte-merged)
//  mem_addr     out  32  byte address = rs1 + imm (ALU result on non-memory ops)
//  new_pc       out  32  current PC register; drives ROM address
// BEHAVIOUR
//  - Reset (reset_n=0, async): PC=RESET_PC, x1..x31=0, mem_wr_sig=0; held until release.
//  - Each edge: PC <= next_pc; rd <= result if rd!=0 and the op writes. x0 reads 0 always.
//  - next_pc: PC+4 default; JAL PC+immJ; JALR (rs1+immI)&~1; branch taken PC+immB.
//  - No alignment traps; targets used as computed (wrap mod 2^32).
//  - Supported: LUI AUIPC JAL JALR BEQ BNE BLT BGE BLTU BGEU, LB LH LW LBU LHU,
//    SB SH SW, ADDI SLTI SLTIU XORI ORI ANDI SLLI SRLI SRAI,
//    ADD SUB SLL SLT SLTU XOR OR AND SRL SRA.
//  - Shifts use shamt[4:0]; SRA/SRAI arithmetic; SLT signed, SLTU unsigned; adds wrap.
//  - Loads: LB/LBU select byte addr[1:0]; LH/LHU select half addr[1]; sign/zero extend.
//    LW ignores addr[1:0].
//  - Stores: mem_wr_sig=1 for the store cycle only.
//    SW writes rs2.
//    SB/SH merge rs2 low byte/half into mem_rd_data at addr[1:0]/addr[1] (read-modify-write).
//  - FENCE, unknown opcodes and ECALL/EBREAK (without CPU_HALT_EN) act as NOP: PC+4, no writes.
//  - mem_wr_sig=0 on every non-store cycle. RAM write and rd write occur on the same edge.
//  - Reset asserted mid-cycle aborts the in-flight instruction; no partial write.
// CONFIGURATION
//  CPU_HALT_EN defined:
//    - ECALL/EBREAK set an internal halted flag (cleared by reset).
//    - While halted: PC frozen, no register writes, mem_wr_sig=0.
//  CPU_HALT_EN undefined: ECALL/EBREAK are NOPs; no halted flag exists.
// STRUCTURE
//  - parameters.vh (shared): opcode, funct3/funct7 and ALU-op localparams.
//  - Submodule rv32i_alu: combinational op, a, b -> result, plus branch compare flags.
//  - Register file, immediate gen, decode, load/store alignment and PC stay in the core.
// TESTING
//  - Reset held 2 cycles, then released -> new_pc=0, mem_wr_sig=0; next edge new_pc=4.
//  - ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SUB x4,x2,x1 -> x3=2, x4=-8.
//    Also SLT x5,x2,x1 -> 1; SLTU x5,x2,x1 -> 0.
//  - LUI x1,0x12345; ADDI x1,x1,0x678; SW x1,8(x0) -> mem_wr_sig=1 for one cycle,
//    mem_addr=8, data 0x12345678.
//    Then LB x2,9(x0) -> 0x56; LH x3,10(x0) -> 0x1234.
//  - SB x5,11(x0) with x5=0xFF over word 0x12345678 -> written 0xFF345678.
//    Then LB x6,11(x0) -> 0xFFFFFFFF; LBU x6 -> 0x000000FF.
//  - BEQ taken +8 skips one instr; BLT -1<1 taken; BLTU 0xFFFFFFFF<1 not taken.
//    JAL x1,+16 at PC 0x20 -> x1=0x24, PC=0x30.
//    JALR x0,0(x1) -> PC=0x24.
//  - ADDI x0,x0,7 -> x0 stays 0.
//    With CPU_HALT_EN, EBREAK at 0x40 -> new_pc stuck at 0x40 until reset.

Source files
------------

// File: rtl/rv32i_core_pkg.sv
// Shared RV32I encodings, ALU operation set and ALU-op decode helper.
// No timing: constants, types and a pure function only.
// No flow control: consumed combinationally by the core and the ALU.
package rv32i_core_pkg;

   // major opcodes
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   // branch funct3
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   // load / store funct3
   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;

   // arithmetic funct3
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;

   typedef enum logic [3:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_SLL,
      ALU_SLT,
      ALU_SLTU,
      ALU_XOR,
      ALU_SRL,
      ALU_SRA,
      ALU_OR,
      ALU_AND,
      ALU_PASS_B
   } alu_op_e;

   // funct7[5] selects SUB only for register-register ops; for shifts it
   // selects arithmetic right shift in both the immediate and register forms.
   function automatic alu_op_e alu_decode(input logic [2:0] f3,
                                          input logic       f7_b5,
                                          input logic       is_reg);
      alu_op_e op;
      case (f3)
         F3_ADD:  op = (is_reg && f7_b5) ? ALU_SUB : ALU_ADD;
         F3_SLL:  op = ALU_SLL;
         F3_SLT:  op = ALU_SLT;
         F3_SLTU: op = ALU_SLTU;
         F3_XOR:  op = ALU_XOR;
         F3_SR:   op = f7_b5 ? ALU_SRA : ALU_SRL;
         F3_OR:   op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage

// File: rtl/rv32i_alu.sv
// RV32I integer ALU with branch comparison flags.
// Purely combinational, zero cycles.
// No flow control: result is valid whenever inputs are.
module rv32i_alu
   import rv32i_core_pkg::*;
(
   input  alu_op_e     op_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] result_o,
   output logic        eq_o,
   output logic        lt_o,
   output logic        ltu_o
);

   assign eq_o  = (a_i == b_i);
   assign lt_o  = ($signed(a_i) < $signed(b_i));
   assign ltu_o = (a_i < b_i);

   // operation select; shifts only honour the low five bits of b
   always_comb begin
      result_o = '0;
      case (op_i)
         ALU_ADD:    result_o = a_i + b_i;
         ALU_SUB:    result_o = a_i - b_i;
         ALU_SLL:    result_o = a_i << b_i[4:0];
         ALU_SLT:    result_o = {31'd0, lt_o};
         ALU_SLTU:   result_o = {31'd0, ltu_o};
         ALU_XOR:    result_o = a_i ^ b_i;
         ALU_SRL:    result_o = a_i >> b_i[4:0];
         ALU_SRA:    result_o = $unsigned($signed(a_i) >>> b_i[4:0]);
         ALU_OR:     result_o = a_i | b_i;
         ALU_AND:    result_o = a_i & b_i;
         ALU_PASS_B: result_o = b_i;
         default:    result_o = '0;
      endcase
   end

endmodule

// File: rtl/rv32i_core.sv
// Single-cycle RV32I core; optional CPU_HALT_EN makes ECALL/EBREAK halt until reset.
// One instruction retires per clk edge; ROM and RAM reads are combinational.
// No backpressure: memories are assumed to answer within the same cycle.
module rv32i_core
   import rv32i_core_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [31:0] instruction,
   input  logic [31:0] mem_rd_data,
   output logic        mem_wr_sig,
   output logic [31:0] mem_wr_data,
   output logic [31:0] mem_addr,
   output logic [31:0] new_pc
);

   // instruction fields
   logic [6:0]  opcode;
   logic [4:0]  rd, rs1, rs2;
   logic [2:0]  funct3;
   logic        funct7_b5;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign opcode    = instruction[6:0];
   assign rd        = instruction[11:7];
   assign funct3    = instruction[14:12];
   assign rs1       = instruction[19:15];
   assign rs2       = instruction[24:20];
   assign funct7_b5 = instruction[30];

   assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
   assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
   assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                   instruction[30:25], instruction[11:8], 1'b0};
   assign imm_u = {instruction[31:12], 12'd0};
   assign imm_j = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                   instruction[20], instruction[30:21], 1'b0};

   // architectural state
   logic [31:0] pc_q, pc_d;
   logic [31:0] rf_q [0:31];

   logic [31:0] rs1_val, rs2_val, pc_plus4;
   assign rs1_val  = (rs1 == 5'd0) ? 32'd0 : rf_q[rs1];
   assign rs2_val  = (rs2 == 5'd0) ? 32'd0 : rf_q[rs2];
   assign pc_plus4 = pc_q + 32'd4;

   // ALU
   alu_op_e     alu_op;
   logic [31:0] alu_a, alu_b, alu_res;
   logic        cmp_eq, cmp_lt, cmp_ltu;

   rv32i_alu u_alu (
      .op_i     (alu_op),
      .a_i      (alu_a),
      .b_i      (alu_b),
      .result_o (alu_res),
      .eq_o     (cmp_eq),
      .lt_o     (cmp_lt),
      .ltu_o    (cmp_ltu)
   );

   // decode controls
   logic        rd_we;
   logic        is_load;
   logic        is_store;
   logic        br_taken;
   logic [31:0] next_pc;
   logic [31:0] ld_val;
   logic [31:0] rd_wdata;
   logic [31:0] st_data;

   // main decode: ALU operands, writeback source and next PC
   always_comb begin
      alu_op   = ALU_ADD;
      alu_a    = rs1_val;
      alu_b    = imm_i;
      rd_we    = 1'b0;
      is_load  = 1'b0;
      is_store = 1'b0;
      br_taken = 1'b0;
      next_pc  = pc_plus4;
      rd_wdata = alu_res;
      case (opcode)
         OP_LUI: begin
            alu_op = ALU_PASS_B;
            alu_b  = imm_u;
            rd_we  = 1'b1;
         end
         OP_AUIPC: begin
            alu_a = pc_q;
            alu_b = imm_u;
            rd_we = 1'b1;
         end
         OP_JAL: begin
            rd_we    = 1'b1;
            rd_wdata = pc_plus4;
            next_pc  = pc_q + imm_j;
         end
         OP_JALR: begin
            rd_we    = 1'b1;
            rd_wdata = pc_plus4;
            next_pc  = {alu_res[31:1], 1'b0};
         end
         OP_BRANCH: begin
            alu_op = ALU_SUB;
            alu_b  = rs2_val;
            case (funct3)
               F3_BEQ:  br_taken = cmp_eq;
               F3_BNE:  br_taken = ~cmp_eq;
               F3_BLT:  br_taken = cmp_lt;
               F3_BGE:  br_taken = ~cmp_lt;
               F3_BLTU: br_taken = cmp_ltu;
               F3_BGEU: br_taken = ~cmp_ltu;
               default: br_taken = 1'b0;
            endcase
            if (br_taken) begin
               next_pc = pc_q + imm_b;
            end
         end
         OP_LOAD: begin
            is_load  = 1'b1;
            rd_we    = 1'b1;
            rd_wdata = ld_val;
         end
         OP_STORE: begin
            alu_b    = imm_s;
            is_store = 1'b1;
         end
         OP_IMM: begin
            alu_op = alu_decode(funct3, funct7_b5, 1'b0);
            rd_we  = 1'b1;
         end
         OP_REG: begin
            alu_op = alu_decode(funct3, funct7_b5, 1'b1);
            alu_b  = rs2_val;
            rd_we  = 1'b1;
         end
         default: begin
            // FENCE, SYSTEM and unknown opcodes retire as NOPs
         end
      endcase
   end

   assign mem_addr = alu_res;

   // load extraction from the addressed RAM word
   always_comb begin
      logic [7:0]  ld_byte;
      logic [15:0] ld_half;
      case (mem_addr[1:0])
         2'd0:    ld_byte = mem_rd_data[7:0];
         2'd1:    ld_byte = mem_rd_data[15:8];
         2'd2:    ld_byte = mem_rd_data[23:16];
         default: ld_byte = mem_rd_data[31:24];
      endcase
      ld_half = mem_addr[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];
      case (funct3)
         F3_LB:   ld_val = {{24{ld_byte[7]}}, ld_byte};
         F3_LH:   ld_val = {{16{ld_half[15]}}, ld_half};
         F3_LBU:  ld_val = {24'd0, ld_byte};
         F3_LHU:  ld_val = {16'd0, ld_half};
         default: ld_val = mem_rd_data;
      endcase
   end

   // store merge: sub-word stores rewrite only their lanes of the current word
   always_comb begin
      st_data = mem_rd_data;
      case (funct3)
         F3_SB: begin
            case (mem_addr[1:0])
               2'd0:    st_data[7:0]   = rs2_val[7:0];
               2'd1:    st_data[15:8]  = rs2_val[7:0];
               2'd2:    st_data[23:16] = rs2_val[7:0];
               default: st_data[31:24] = rs2_val[7:0];
            endcase
         end
         F3_SH: begin
            if (mem_addr[1]) begin
               st_data[31:16] = rs2_val[15:0];
            end else begin
               st_data[15:0] = rs2_val[15:0];
            end
         end
         default: st_data = rs2_val;
      endcase
   end

   assign mem_wr_data = st_data;

   // commit gate: only the halt feature can stop an instruction retiring
   logic commit;
`ifdef CPU_HALT_EN
   logic is_sys;
   logic halted_q, halted_d;
   // ECALL and EBREAK share funct3=0; CSR ops remain NOPs
   assign is_sys   = (opcode == OP_SYSTEM) && (funct3 == 3'b000);
   assign commit   = ~halted_q & ~is_sys;
   assign halted_d = halted_q | is_sys;

   // sticky halted flag, only reset clears it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         halted_q <= 1'b0;
      end else begin
         halted_q <= halted_d;
      end
   end
`else
   assign commit = 1'b1;
`endif

   assign pc_d = commit ? next_pc : pc_q;

   // gating with reset_n keeps an aborted store from reaching the RAM edge
   assign mem_wr_sig = is_store & commit & reset_n;
   assign new_pc     = pc_q;

   // program counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   // register file write port; x0 is never written
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < 32; i++) begin
            rf_q[i] <= 32'd0;
         end
      end else if (commit && rd_we && (rd != 5'd0)) begin
         rf_q[rd] <= rd_wdata;
      end
   end

   // is_load only documents intent in decode; keep it observable to lint
   logic unused_ok;
   assign unused_ok = is_load;

endmodule

// File: tb/tb_rv32i_core.sv
// Directed bench for rv32i_core with behavioural ROM/RAM around the core.
// Each task loads a program, resets, steps clocks and compares on negedges.
// Results are observed through stores into the bench RAM and the PC output.
module tb_rv32i_core;

   localparam logic [6:0] O_LUI   = 7'b0110111;
   localparam logic [6:0] O_AUIPC = 7'b0010111;
   localparam logic [6:0] O_JALR  = 7'b1100111;
   localparam logic [6:0] O_LOAD  = 7'b0000011;
   localparam logic [6:0] O_IMM   = 7'b0010011;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk;
   logic        reset_n;
   logic [31:0] instruction;
   logic [31:0] mem_rd_data;
   logic        mem_wr_sig;
   logic [31:0] mem_wr_data;
   logic [31:0] mem_addr;
   logic [31:0] new_pc;

   logic [31:0] rom [0:255];
   logic [31:0] ram [0:255];
   logic        ram_clr;
   int          wr_count;
   int          vecs;
   int          errs;

   rv32i_core #(.RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .instruction (instruction),
      .mem_rd_data (mem_rd_data),
      .mem_wr_sig  (mem_wr_sig),
      .mem_wr_data (mem_wr_data),
      .mem_addr    (mem_addr),
      .new_pc      (new_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign instruction = rom[new_pc[9:2]];
   assign mem_rd_data = ram[mem_addr[9:2]];

   always @(posedge clk) begin
      if (ram_clr) begin
         for (int i = 0; i < 256; i++) ram[i] <= 32'd0;
         wr_count <= 0;
      end else if (mem_wr_sig) begin
         ram[mem_addr[9:2]] <= mem_wr_data;
         wr_count <= wr_count + 1;
      end
   end

   // ---------------- encoders ----------------
   function automatic logic [31:0] enc_i(input logic [31:0] imm, input logic [31:0] rs1,
                                         input logic [31:0] f3, input logic [31:0] rd,
                                         input logic [6:0] op);
      return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
   endfunction
   function automatic logic [31:0] enc_r(input logic [31:0] f7, input logic [31:0] rs2,
                                         input logic [31:0] rs1, input logic [31:0] f3,
                                         input logic [31:0] rd);
      return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
   endfunction
   function automatic logic [31:0] enc_s(input logic [31:0] imm, input logic [31:0] rs2,
                                         input logic [31:0] rs1, input logic [31:0] f3);
      return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
   endfunction
   function automatic logic [31:0] enc_b(input logic [31:0] imm, input logic [31:0] rs2,
                                         input logic [31:0] rs1, input logic [31:0] f3);
      return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
   endfunction
   function automatic logic [31:0] enc_u(input logic [31:0] imm20, input logic [31:0] rd,
                                         input logic [6:0] op);
      return {imm20[19:0], rd[4:0], op};
   endfunction
   function automatic logic [31:0] enc_j(input logic [31:0] imm, input logic [31:0] rd);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
   endfunction

   // ---------------- helpers ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic clear_rom();
      for (int i = 0; i < 256; i++) rom[i] = NOP;
   endtask

   task automatic do_reset();
      ram_clr = 1'b1;
      reset_n = 1'b0;
      cyc(2);
      ram_clr = 1'b0;
      reset_n = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      clear_rom();
      ram_clr = 1'b1;
      reset_n = 1'b0;
      cyc(2);
      vecs++; if (new_pc !== 32'h0) begin errs++; $display("FAIL rst_pc_held got %h want %h", new_pc, 32'h0); end
      vecs++; if (mem_wr_sig !== 1'b0) begin errs++; $display("FAIL rst_wr_held got %b want 0", mem_wr_sig); end
      ram_clr = 1'b0;
      reset_n = 1'b1;
      vecs++; if (new_pc !== 32'h0) begin errs++; $display("FAIL rst_pc_release got %h want %h", new_pc, 32'h0); end
      cyc(1);
      vecs++; if (new_pc !== 32'h4) begin errs++; $display("FAIL rst_pc_first got %h want %h", new_pc, 32'h4); end
      cyc(2);
      vecs++; if (new_pc !== 32'hC) begin errs++; $display("FAIL rst_pc_third got %h want %h", new_pc, 32'hC); end
      reset_n = 1'b0;
      #1;
      vecs++; if (new_pc !== 32'h0) begin errs++; $display("FAIL rst_async got %h want %h", new_pc, 32'h0); end
      cyc(1);
      reset_n = 1'b1;
   endtask

   task automatic test_alu();
      logic [31:0] exp_m [0:11];
      exp_m = '{32'h2, 32'hFFFF_FFF8, 32'h1, 32'h0, 32'hFFFF_FFFE, 32'hF,
                32'hA0, 32'hFFFF_FFF2, 32'h5, 32'h1058, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
      clear_rom();
      rom[0]  = enc_i(5, 0, 0, 1, O_IMM);
      rom[1]  = enc_i(-3, 0, 0, 2, O_IMM);
      rom[2]  = enc_r(0, 2, 1, 0, 3);
      rom[3]  = enc_r(32, 1, 2, 0, 4);
      rom[4]  = enc_r(0, 1, 2, 2, 5);
      rom[5]  = enc_s(0, 3, 0, 2);
      rom[6]  = enc_s(4, 4, 0, 2);
      rom[7]  = enc_s(8, 5, 0, 2);
      rom[8]  = enc_r(0, 1, 2, 3, 5);
      rom[9]  = enc_s(12, 5, 0, 2);
      rom[10] = enc_i(32'h401, 2, 5, 6, O_IMM);
      rom[11] = enc_s(16, 6, 0, 2);
      rom[12] = enc_i(28, 2, 5, 7, O_IMM);
      rom[13] = enc_s(20, 7, 0, 2);
      rom[14] = enc_r(0, 1, 1, 1, 8);
      rom[15] = enc_s(24, 8, 0, 2);
      rom[16] = enc_i(32'h0F, 2, 4, 9, O_IMM);
      rom[17] = enc_s(28, 9, 0, 2);
      rom[18] = enc_i(7, 0, 0, 0, O_IMM);
      rom[19] = NOP;
      rom[20] = enc_r(0, 1, 0, 0, 10);
      rom[21] = enc_s(32, 10, 0, 2);
      rom[22] = enc_u(1, 11, O_AUIPC);
      rom[23] = enc_s(36, 11, 0, 2);
      rom[24] = enc_r(0, 2, 1, 6, 12);
      rom[25] = enc_s(40, 12, 0, 2);
      rom[26] = enc_r(32, 1, 2, 5, 13);
      rom[27] = enc_s(44, 13, 0, 2);
      do_reset();
      cyc(28);
      for (int i = 0; i < 12; i++) begin
         vecs++;
         if (ram[i] !== exp_m[i]) begin
            errs++; $display("FAIL alu_word%0d got %h want %h", i, ram[i], exp_m[i]);
         end
      end
      vecs++; if (wr_count !== 12) begin errs++; $display("FAIL alu_store_count got %0d want 12", wr_count); end
   endtask

   task automatic test_load_store();
      logic [31:0] exp_m [0:10];
      exp_m = '{32'h0, 32'h0, 32'hFF34_00FF, 32'h0, 32'hFFFF_FFFF, 32'hFF,
                32'h56, 32'h1234, 32'hFFFF_FF34, 32'h0000_FF34, 32'hFF34_00FF};
      clear_rom();
      rom[0]  = enc_u(32'h12345, 1, O_LUI);
      rom[1]  = enc_i(32'h678, 1, 0, 1, O_IMM);
      rom[2]  = enc_s(8, 1, 0, 2);
      rom[3]  = enc_i(9, 0, 0, 2, O_LOAD);
      rom[4]  = enc_i(10, 0, 1, 3, O_LOAD);
      rom[5]  = enc_i(32'hFF, 0, 0, 5, O_IMM);
      rom[6]  = enc_s(11, 5, 0, 0);
      rom[7]  = enc_i(11, 0, 0, 6, O_LOAD);
      rom[8]  = enc_s(16, 6, 0, 2);
      rom[9]  = enc_i(11, 0, 4, 6, O_LOAD);
      rom[10] = enc_s(20, 6, 0, 2);
      rom[11] = enc_s(24, 2, 0, 2);
      rom[12] = enc_s(28, 3, 0, 2);
      rom[13] = enc_i(10, 0, 1, 7, O_LOAD);
      rom[14] = enc_s(32, 7, 0, 2);
      rom[15] = enc_i(10, 0, 5, 8, O_LOAD);
      rom[16] = enc_s(36, 8, 0, 2);
      rom[17] = enc_s(8, 5, 0, 1);
      rom[18] = enc_i(9, 0, 2, 9, O_LOAD);
      rom[19] = enc_s(40, 9, 0, 2);
      do_reset();
      cyc(2);
      vecs++; if (mem_wr_sig !== 1'b1) begin errs++; $display("FAIL sw_wr got %b want 1", mem_wr_sig); end
      vecs++; if (mem_addr !== 32'h8) begin errs++; $display("FAIL sw_addr got %h want %h", mem_addr, 32'h8); end
      vecs++; if (mem_wr_data !== 32'h1234_5678) begin errs++; $display("FAIL sw_data got %h want %h", mem_wr_data, 32'h1234_5678); end
      cyc(1);
      vecs++; if (mem_wr_sig !== 1'b0) begin errs++; $display("FAIL sw_wr_drop got %b want 0", mem_wr_sig); end
      cyc(3);
      vecs++; if (mem_addr !== 32'hB) begin errs++; $display("FAIL sb_addr got %h want %h", mem_addr, 32'hB); end
      vecs++; if (mem_wr_data !== 32'hFF34_5678) begin errs++; $display("FAIL sb_merge got %h want %h", mem_wr_data, 32'hFF34_5678); end
      cyc(14);
      for (int i = 2; i < 11; i++) begin
         if (i != 3) begin
            vecs++;
            if (ram[i] !== exp_m[i]) begin
               errs++; $display("FAIL ldst_word%0d got %h want %h", i, ram[i], exp_m[i]);
            end
         end
      end
      vecs++; if (wr_count !== 10) begin errs++; $display("FAIL ldst_store_count got %0d want 10", wr_count); end
   endtask

   task automatic test_branch();
      logic [31:0] exp_pc [0:12];
      exp_pc = '{32'h0, 32'h4, 32'h8, 32'h10, 32'h18, 32'h1C, 32'h20,
                 32'h30, 32'h24, 32'h28, 32'h2C, 32'h30, 32'h24};
      clear_rom();
      rom[0]  = enc_i(-1, 0, 0, 1, O_IMM);
      rom[1]  = enc_i(1, 0, 0, 2, O_IMM);
      rom[2]  = enc_b(8, 0, 0, 0);
      rom[3]  = enc_i(99, 0, 0, 3, O_IMM);
      rom[4]  = enc_b(8, 2, 1, 4);
      rom[5]  = enc_i(98, 0, 0, 3, O_IMM);
      rom[6]  = enc_b(8, 2, 1, 6);
      rom[7]  = enc_i(7, 0, 0, 4, O_IMM);
      rom[8]  = enc_j(16, 1);
      rom[9]  = enc_s(0, 1, 0, 2);
      rom[10] = enc_s(4, 3, 0, 2);
      rom[11] = enc_s(8, 4, 0, 2);
      rom[12] = enc_i(0, 1, 0, 0, O_JALR);
      do_reset();
      for (int i = 0; i < 13; i++) begin
         vecs++;
         if (new_pc !== exp_pc[i]) begin
            errs++; $display("FAIL br_pc_step%0d got %h want %h", i, new_pc, exp_pc[i]);
         end
         cyc(1);
      end
      vecs++; if (ram[0] !== 32'h24) begin errs++; $display("FAIL jal_link got %h want %h", ram[0], 32'h24); end
      vecs++; if (ram[1] !== 32'h0) begin errs++; $display("FAIL br_skipped got %h want %h", ram[1], 32'h0); end
      vecs++; if (ram[2] !== 32'h7) begin errs++; $display("FAIL bltu_fallthru got %h want %h", ram[2], 32'h7); end
   endtask

   task automatic test_branch2();
      logic [31:0] exp_pc [0:7];
      exp_pc = '{32'h0, 32'h4, 32'hC, 32'h10, 32'h18, 32'h100, 32'h104, 32'h100};
      clear_rom();
      rom[0]  = enc_i(-1, 0, 0, 1, O_IMM);
      rom[1]  = enc_b(8, 0, 1, 1);
      rom[3]  = enc_b(8, 0, 1, 5);
      rom[4]  = enc_b(8, 0, 1, 7);
      rom[6]  = enc_i(32'h101, 0, 0, 5, O_JALR);
      rom[64] = enc_s(0, 5, 0, 2);
      rom[65] = enc_b(-4, 0, 0, 0);
      do_reset();
      for (int i = 0; i < 8; i++) begin
         vecs++;
         if (new_pc !== exp_pc[i]) begin
            errs++; $display("FAIL br2_pc_step%0d got %h want %h", i, new_pc, exp_pc[i]);
         end
         cyc(1);
      end
      vecs++; if (ram[0] !== 32'h1C) begin errs++; $display("FAIL jalr_link got %h want %h", ram[0], 32'h1C); end
   endtask

   task automatic test_system();
      logic [31:0] exp_after;
`ifdef CPU_HALT_EN
      exp_after = 32'h40;
`else
      exp_after = 32'h4C;
`endif
      clear_rom();
      rom[0]  = 32'h0000_000F;
      rom[1]  = enc_i(3, 0, 0, 1, O_IMM);
      rom[2]  = enc_s(0, 1, 0, 2);
      rom[16] = 32'h0010_0073;
      rom[17] = 32'h0000_0073;
      do_reset();
      cyc(16);
      vecs++; if (new_pc !== 32'h40) begin errs++; $display("FAIL sys_reach got %h want %h", new_pc, 32'h40); end
      vecs++; if (ram[0] !== 32'h3) begin errs++; $display("FAIL fence_nop got %h want %h", ram[0], 32'h3); end
      cyc(3);
      vecs++; if (new_pc !== exp_after) begin errs++; $display("FAIL ebreak_pc got %h want %h", new_pc, exp_after); end
      do_reset();
      cyc(1);
      vecs++; if (new_pc !== 32'h4) begin errs++; $display("FAIL sys_rerun got %h want %h", new_pc, 32'h4); end
   endtask

   task automatic test_abort();
      clear_rom();
      rom[0] = enc_i(32'h55, 0, 0, 1, O_IMM);
      rom[1] = enc_s(0, 1, 0, 2);
      do_reset();
      cyc(1);
      vecs++; if (mem_wr_sig !== 1'b1) begin errs++; $display("FAIL abort_pre_wr got %b want 1", mem_wr_sig); end
      reset_n = 1'b0;
      #1;
      vecs++; if (mem_wr_sig !== 1'b0) begin errs++; $display("FAIL abort_wr got %b want 0", mem_wr_sig); end
      cyc(1);
      vecs++; if (ram[0] !== 32'h0) begin errs++; $display("FAIL abort_ram got %h want %h", ram[0], 32'h0); end
      vecs++; if (new_pc !== 32'h0) begin errs++; $display("FAIL abort_pc got %h want %h", new_pc, 32'h0); end
      reset_n = 1'b1;
      cyc(1);
   endtask

   initial begin
      vecs    = 0;
      errs    = 0;
      reset_n = 1'b0;
      ram_clr = 1'b1;
      clear_rom();
      test_reset();
      test_alu();
      test_load_store();
      test_branch();
      test_branch2();
      test_system();
      test_abort();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
